// File: rtl/read_arb_pkg.sv
// Shared definitions for the SDRAM read-source arbiter.
//   arb_state_e      : arbiter FSM states
//   FRAME_PIXELS_DEF : default pixels per frame (320x240)
//   PIX_W            : width of the per-frame pixel counter
//   DATA_W           : width of a pixel word from the read FIFO
package read_arb_pkg;

  localparam int FRAME_PIXELS_DEF = 76800;
  localparam int PIX_W            = 17;
  localparam int DATA_W           = 16;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_VGA,
    ST_H_IDLE,
    ST_H_RD,
    ST_H_CAP,
    ST_H_ACK
  } arb_state_e;

endpackage

// File: rtl/read_source_arbiter_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output and stage flop clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clock edges behind d
module arb_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/read_source_arbiter.sv
// Arbitrates the SDRAM read FIFO between the VGA scan-out and the HPS.
// The VGA owner streams pixels with zero-latency strobes; the HPS owner
// fetches one pixel per level handshake. Ownership only changes through a
// LOAD phase that rewinds the read FIFO to the frame start.
//
// Optional feature: define READ_ARB_FRAME_CNT_EN to add oFRAME_CNT, a
// 16-bit count of frame ends since the last LOAD.
//
// Ports:
//   iCLK       : sole clock, rising edge
//   iRST_N     : asynchronous active-low reset
//   iSRC_SEL   : requested owner, 0 = VGA, 1 = HPS (asynchronous)
//   iVGA_REQ   : per-pixel read request from the VGA controller
//   iHPS_REQ   : HPS level handshake request (asynchronous)
//   iRD_DATA   : read-FIFO data, valid the cycle after a strobe
//   oRD        : read-FIFO read strobe
//   oRD_LOAD   : read-FIFO address reload to frame start
//   oHPS_DATA  : pixel captured for the HPS
//   oHPS_ACK   : HPS handshake acknowledge
//   oGRANT     : current owner, 0 = VGA, 1 = HPS
//   oPIX_CNT   : pixels read in the current frame
//   oFRAME_CNT : frame ends since last LOAD (READ_ARB_FRAME_CNT_EN only)
module read_source_arbiter
  import read_arb_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int LOAD_CYCLES  = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSRC_SEL,
  input  logic              iVGA_REQ,
  input  logic              iHPS_REQ,
  input  logic [DATA_W-1:0] iRD_DATA,
  output logic              oRD,
  output logic              oRD_LOAD,
  output logic [DATA_W-1:0] oHPS_DATA,
  output logic              oHPS_ACK,
  output logic              oGRANT,
  output logic [PIX_W-1:0]  oPIX_CNT
`ifdef READ_ARB_FRAME_CNT_EN
  ,
  output logic [15:0]       oFRAME_CNT
`endif
);

  localparam int LCNT_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [LCNT_W-1:0] load_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [DATA_W-1:0] hps_data;
  logic              grant;
  logic              src_s;
  logic              req_s;
  logic              rd;
  logic              load_out;
  logic              ack;
  logic              load_last;
  logic              last_pix;

  function automatic logic [PIX_W-1:0] next_pix(input logic [PIX_W-1:0] p);
    return (p == PIX_W'(FRAME_PIXELS - 1)) ? '0 : p + 1'b1;
  endfunction

  arb_sync2 u_sync_src (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .d     (iSRC_SEL),
    .q     (src_s)
  );

  arb_sync2 u_sync_req (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .d     (iHPS_REQ),
    .q     (req_s)
  );

  assign load_last = (load_cnt == LCNT_W'(LOAD_CYCLES - 1));
  assign last_pix  = (pix_cnt == PIX_W'(FRAME_PIXELS - 1));

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    load_out  = 1'b0;
    ack       = 1'b0;
    case (state)
      ST_LOAD: begin
        load_out = 1'b1;
        if (load_last) state_nxt = src_s ? ST_H_IDLE : ST_VGA;
      end
      ST_VGA: begin
        rd = iVGA_REQ;
        // An ownership request is only honoured on the read that ends the frame.
        if (iVGA_REQ && last_pix && src_s) state_nxt = ST_LOAD;
      end
      ST_H_IDLE: begin
        if (!src_s)     state_nxt = ST_LOAD;
        else if (req_s) state_nxt = ST_H_RD;
      end
      ST_H_RD: begin
        rd        = 1'b1;
        state_nxt = ST_H_CAP;
      end
      ST_H_CAP: begin
        state_nxt = ST_H_ACK;
      end
      ST_H_ACK: begin
        ack = 1'b1;
        if (!req_s) state_nxt = ST_H_IDLE;
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_LOAD;
      load_cnt <= '0;
      grant    <= 1'b0;
      pix_cnt  <= '0;
      hps_data <= '0;
    end else begin
      state    <= state_nxt;
      load_cnt <= (state == ST_LOAD && !load_last) ? load_cnt + 1'b1 : '0;
      if (state == ST_LOAD && load_last) grant <= src_s;
      // Clearing on entry keeps the count at zero for the whole LOAD phase.
      if (state_nxt == ST_LOAD) pix_cnt <= '0;
      else if (rd)              pix_cnt <= next_pix(pix_cnt);
      if (state == ST_H_CAP) hps_data <= iRD_DATA;
    end
  end

`ifdef READ_ARB_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                frame_cnt <= '0;
    else if (state_nxt == ST_LOAD) frame_cnt <= '0;
    else if (rd && last_pix)    frame_cnt <= frame_cnt + 1'b1;
  end

  assign oFRAME_CNT = frame_cnt;
`endif

  // The FSM rests in LOAD while reset is held, but the reload must stay quiet.
  assign oRD_LOAD  = load_out & iRST_N;
  assign oRD       = rd;
  assign oHPS_ACK  = ack;
  assign oGRANT    = grant;
  assign oHPS_DATA = hps_data;
  assign oPIX_CNT  = pix_cnt;

endmodule

// File: tb/tb_read_source_arbiter.sv
module tb_read_source_arbiter;

  localparam int FP = 640;
  localparam int LC = 4;

  logic        clk;
  logic        rst_n;
  logic        src;
  logic        vga;
  logic        hreq;
  logic [15:0] rd_data;
  logic        oRD;
  logic        oRD_LOAD;
  logic [15:0] oHPS_DATA;
  logic        oHPS_ACK;
  logic        oGRANT;
  logic [16:0] oPIX_CNT;
`ifdef READ_ARB_FRAME_CNT_EN
  logic [15:0] oFRAME_CNT;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        chk_en = 1'b0;
  logic        rd_prev = 1'b0;
  logic [15:0] fifo_word = 16'h0000;

  read_source_arbiter #(.FRAME_PIXELS(FP), .LOAD_CYCLES(LC)) dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .iSRC_SEL  (src),
    .iVGA_REQ  (vga),
    .iHPS_REQ  (hreq),
    .iRD_DATA  (rd_data),
    .oRD       (oRD),
    .oRD_LOAD  (oRD_LOAD),
    .oHPS_DATA (oHPS_DATA),
    .oHPS_ACK  (oHPS_ACK),
    .oGRANT    (oGRANT),
    .oPIX_CNT  (oPIX_CNT)
`ifdef READ_ARB_FRAME_CNT_EN
    ,
    .oFRAME_CNT(oFRAME_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Read FIFO stand-in: the word appears only the cycle after a strobe.
  always @(negedge clk) rd_prev <= oRD;
  always @(posedge clk) begin
    #2;
    rd_data = rd_prev ? fifo_word : 16'h0BAD;
  end

  // Behavioural model: ownership mode, reads since last reload, captured word.
  typedef enum int {M_LOADING, M_VGA, M_WAIT, M_STROBE, M_CAPTURE, M_ACKING} mode_t;
  mode_t       mode, n_mode;
  int          reads, n_reads, load_left, n_left;
  logic        owner, n_owner;
  logic [15:0] m_data, n_data;
  logic        ss1, ss2, rs1, rs2;

  always_comb begin
    n_mode  = mode;
    n_reads = reads;
    n_left  = load_left;
    n_owner = owner;
    n_data  = m_data;
    case (mode)
      M_LOADING: begin
        n_reads = 0;
        n_left  = load_left - 1;
        if (n_left == 0) begin
          n_owner = ss2;
          n_mode  = ss2 ? M_WAIT : M_VGA;
          n_left  = LC;
        end
      end
      M_VGA: if (vga) begin
        n_reads = reads + 1;
        if (n_reads % FP == 0 && ss2 != owner) begin
          n_mode  = M_LOADING;
          n_reads = 0;
        end
      end
      M_WAIT: begin
        if (!ss2) begin
          n_mode  = M_LOADING;
          n_reads = 0;
        end else if (rs2) n_mode = M_STROBE;
      end
      M_STROBE: begin
        n_reads = reads + 1;
        n_mode  = M_CAPTURE;
      end
      M_CAPTURE: begin
        n_data = rd_data;
        n_mode = M_ACKING;
      end
      M_ACKING: if (!rs2) n_mode = M_WAIT;
      default: n_mode = M_LOADING;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= M_LOADING; reads <= 0; load_left <= LC; owner <= 1'b0; m_data <= 16'h0;
      ss1 <= 1'b0; ss2 <= 1'b0; rs1 <= 1'b0; rs2 <= 1'b0;
    end else begin
      mode <= n_mode; reads <= n_reads; load_left <= n_left; owner <= n_owner; m_data <= n_data;
      ss1 <= src; ss2 <= ss1; rs1 <= hreq; rs2 <= rs1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rd",    oRD,       (mode == M_VGA && vga) || mode == M_STROBE);
      chk("m_load",  oRD_LOAD,  mode == M_LOADING && rst_n);
      chk("m_ack",   oHPS_ACK,  mode == M_ACKING);
      chk("m_grant", oGRANT,    owner);
      chk("m_pix",   oPIX_CNT,  reads % FP);
      chk("m_data",  oHPS_DATA, m_data);
`ifdef READ_ARB_FRAME_CNT_EN
      chk("m_frames", oFRAME_CNT, (reads / FP) % 65536);
`endif
    end
  end

  task automatic count_load(output int n);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (oRD_LOAD) n++;
    end
  endtask

  task automatic wait_load(input int max, output logic seen, output int rds);
    seen = 1'b0;
    rds  = 0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk);
      if (oRD_LOAD) seen = 1'b1;
      else if (oRD) rds++;
    end
  endtask

  task automatic handshake(input logic [15:0] w, output int rds);
    int n;
    rds = 0;
    fifo_word = w;
    @(posedge clk); #2; hreq = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (oRD) rds++;
      n++;
    end while (!oHPS_ACK && n < 20);
    if (!oHPS_ACK) chk("hs_ack_timeout", oHPS_ACK, 1'b1);
    @(posedge clk); #2; hreq = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (oHPS_ACK && n < 20);
    if (oHPS_ACK) chk("hs_release_timeout", oHPS_ACK, 1'b0);
  endtask

  initial begin
    int   n, r, prev;
    logic seen;
    rst_n = 1'b0; src = 1'b0; vga = 1'b0; hreq = 1'b0; rd_data = 16'h0;
    repeat (3) @(posedge clk);
    #2 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_load",  oRD_LOAD,  1'b0);
    chk("rst_grant", oGRANT,    1'b0);
    chk("rst_pix",   oPIX_CNT,  0);
    chk("rst_ack",   oHPS_ACK,  1'b0);
    chk("rst_data",  oHPS_DATA, 16'h0);

    // Boot into VGA ownership.
    @(posedge clk); #2 rst_n = 1'b1;
    count_load(n);
    chk("boot_load_len", n, 4);
    chk("boot_grant", oGRANT, 1'b0);

    @(posedge clk); #2 vga = 1'b1;
    @(negedge clk);
    chk("vga_rd_same_cycle", oRD, 1'b1);
    repeat (100) @(posedge clk);
    #2 vga = 1'b0;
    @(negedge clk);
    chk("vga_pix_100", oPIX_CNT, 100);
    chk("vga_rd_off", oRD, 1'b0);

    // Switch request mid-frame is deferred until the frame's last read.
    @(posedge clk); #2 src = 1'b1;
    seen = 1'b0;
    prev = -1;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(posedge clk); #2 vga = (k % 4) != 3;
      @(negedge clk);
      if (oRD_LOAD) seen = 1'b1;
      else prev = int'(oPIX_CNT);
    end
    chk("frame_end_seen", seen, 1'b1);
    chk("last_pix_before_load", prev, FP - 1);
    chk("load_pix_zero", oPIX_CNT, 0);
    chk("grant_held_in_load", oGRANT, 1'b0);
    @(posedge clk); #2 vga = 1'b0;
    count_load(n);
    chk("switch_load_rest", n, 3);
    chk("switch_grant_hps", oGRANT, 1'b1);

    // HPS single-pixel handshakes.
    handshake(16'hA5C3, r);
    chk("hs1_one_strobe", r, 1);
    chk("hs1_data", oHPS_DATA, 16'hA5C3);
    chk("hs1_pix", oPIX_CNT, 1);
    handshake(16'h5A3C, r);
    chk("hs2_data", oHPS_DATA, 16'h5A3C);
    chk("hs2_pix", oPIX_CNT, 2);
    for (int k = 0; k < 600 && oPIX_CNT < 500; k++) begin
      handshake(16'h1000 + 16'(k), r);
    end
    chk("hs_pix_500", oPIX_CNT, 500);

    // Source drop and request arrive together: reload wins.
    @(posedge clk); #2;
    src = 1'b0;
    hreq = 1'b1;
    wait_load(12, seen, r);
    chk("drop_load_seen", seen, 1'b1);
    chk("drop_no_strobe", r, 0);
    chk("drop_pix_zero", oPIX_CNT, 0);
    @(posedge clk); #2 hreq = 1'b0;
    count_load(n);
    chk("drop_load_rest", n, 3);
    chk("drop_grant_vga", oGRANT, 1'b0);

    // Back to HPS via a full VGA frame, then reset mid-acknowledge.
    @(posedge clk); #2;
    src = 1'b1;
    vga = 1'b1;
    wait_load(1000, seen, r);
    chk("frame2_load_seen", seen, 1'b1);
    chk("frame2_reads", r, FP);
    @(posedge clk); #2 vga = 1'b0;
    count_load(n);
    chk("frame2_grant_hps", oGRANT, 1'b1);
    fifo_word = 16'hBEEF;
    @(posedge clk); #2 hreq = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oHPS_ACK && n < 20);
    chk("ack_before_reset", oHPS_ACK, 1'b1);
    chk("data_before_reset", oHPS_DATA, 16'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ack_drop", oHPS_ACK, 1'b0);
    chk("reset_data_zero", oHPS_DATA, 16'h0);
    chk("reset_grant_zero", oGRANT, 1'b0);
    chk("reset_load_low", oRD_LOAD, 1'b0);
    src = 1'b0;
    hreq = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    count_load(n);
    chk("rerun_load_len", n, 4);
    chk("rerun_grant_vga", oGRANT, 1'b0);

`ifdef READ_ARB_FRAME_CNT_EN
    @(posedge clk); #2 vga = 1'b1;
    repeat (3 * FP) @(posedge clk);
    #2 vga = 1'b0;
    @(negedge clk);
    chk("fc_three", oFRAME_CNT, 3);
    chk("fc_pix_zero", oPIX_CNT, 0);
    @(posedge clk); #2;
    src = 1'b1;
    vga = 1'b1;
    wait_load(1000, seen, r);
    chk("fc_load_seen", seen, 1'b1);
    chk("fc_cleared", oFRAME_CNT, 0);
    @(posedge clk); #2 vga = 1'b0;
`endif

    repeat (5) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
